// File: rtl/muladd_result_checker.sv
// Cycle-aligned golden checker for the fused mul-add pipeline: delayed reference, compare, count, done/pass.
// Optional compare/result logging is enabled by defining MULADD_CHECK_LOG_EN.
module muladd_result_checker #(
  parameter int WIDTH      = 8,
  parameter int LATENCY    = 2,
  parameter int WARMUP     = 4995,
  parameter int NUM_CHECKS = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] exp_y,
  output logic             exp_valid,
  output logic             mismatch,
  output logic [15:0]      err_count,
  output logic [31:0]      check_count,
  output logic             done,
  output logic             pass
);

  typedef enum logic [1:0] {
    ST_WARMUP,
    ST_CHECK,
    ST_DONE
  } state_t;

  state_t             state;
  logic [31:0]        cycles;
  logic [WIDTH-1:0]   stage [LATENCY];
  logic [LATENCY-1:0] valid;
  logic [WIDTH-1:0]   golden;
  logic               compare_event;
  logic               differs;
  logic [15:0]        err_next;

  // The low WIDTH bits of a signed product/sum equal those of the unsigned one,
  // so the wrapped result needs no sign extension or full-width product.
  assign golden = a * b + c;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage[i] <= '0;
      end
      valid <= '0;
    end else if (en) begin
      stage[0] <= golden;
      valid[0] <= 1'b1;
      for (int i = LATENCY - 1; i > 0; i--) begin
        stage[i] <= stage[i-1];
        valid[i] <= valid[i-1];
      end
    end
  end

  assign exp_y     = stage[LATENCY-1];
  assign exp_valid = valid[LATENCY-1];

  assign compare_event = (state == ST_CHECK) && en && exp_valid;
  assign differs       = (y != exp_y);
  assign err_next      = (differs && (err_count != 16'hFFFF)) ? err_count + 16'd1 : err_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_WARMUP;
      cycles      <= '0;
      mismatch    <= 1'b0;
      err_count   <= '0;
      check_count <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
    end else begin
      mismatch <= 1'b0;
      case (state)
        ST_WARMUP: begin
          cycles <= cycles + 32'd1;
          if (cycles == 32'(WARMUP - 1)) begin
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          cycles <= cycles + 32'd1;
          if (compare_event) begin
            check_count <= check_count + 32'd1;
            err_count   <= err_next;
            mismatch    <= differs;
`ifdef MULADD_CHECK_LOG_EN
            $display("[cycles=%4d] r:%2d, e:%2d %s", cycles, $signed(y), $signed(exp_y),
                     differs ? "ERR" : "OK");
`endif
            // pass must see this compare's error, hence err_next rather than err_count
            if (check_count + 32'd1 == 32'(NUM_CHECKS)) begin
              state <= ST_DONE;
              done  <= 1'b1;
              pass  <= (err_next == 16'd0);
`ifdef MULADD_CHECK_LOG_EN
              if (err_next == 16'd0) $display("PASS");
              else $display("FAIL errors=%0d", err_next);
`endif
            end
          end
        end
        ST_DONE: begin
          state <= ST_DONE;
        end
        default: begin
          state <= ST_WARMUP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muladd_result_checker.sv
// Randomized bench for muladd_result_checker against a queue-based reference model,
// plus a parallel long run that drives err_count into saturation.
module tb_muladd_result_checker;
  localparam int WIDTH      = 8;
  localparam int LATENCY    = 2;
  localparam int WARMUP     = 10;
  localparam int NUM_CHECKS = 16;
  localparam int SAT_CHECKS = 70000;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic             reset, en;
  logic [WIDTH-1:0] a, b, c, y;
  logic [WIDTH-1:0] exp_y;
  logic             exp_valid, mismatch, done, pass;
  logic [15:0]      err_count;
  logic [31:0]      check_count;

  logic             reset2, en2;
  logic [WIDTH-1:0] a2, b2, c2, y2;
  logic [WIDTH-1:0] exp_y2;
  logic             exp_valid2, mismatch2, done2, pass2;
  logic [15:0]      err_count2;
  logic [31:0]      check_count2;

  muladd_result_checker #(.WIDTH(WIDTH), .LATENCY(LATENCY), .WARMUP(WARMUP), .NUM_CHECKS(NUM_CHECKS)) dut (
    .clock(clock), .reset(reset), .en(en), .a(a), .b(b), .c(c), .y(y),
    .exp_y(exp_y), .exp_valid(exp_valid), .mismatch(mismatch), .err_count(err_count),
    .check_count(check_count), .done(done), .pass(pass)
  );

  muladd_result_checker #(.WIDTH(WIDTH), .LATENCY(LATENCY), .WARMUP(WARMUP), .NUM_CHECKS(SAT_CHECKS)) dut_sat (
    .clock(clock), .reset(reset2), .en(en2), .a(a2), .b(b2), .c(c2), .y(y2),
    .exp_y(exp_y2), .exp_valid(exp_valid2), .mismatch(mismatch2), .err_count(err_count2),
    .check_count(check_count2), .done(done2), .pass(pass2)
  );

  int checks = 0;
  int errors = 0;
  bit sat_finished = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, want);
    end
  endtask

  // Reference model: history of golden values of every enabled cycle since reset.
  logic [WIDTH-1:0] hist[$];
  int  m_edges, m_checks, m_errs;
  bit  m_done, m_mis;

  function automatic logic [WIDTH-1:0] gold(input logic [WIDTH-1:0] ia, ib, ic);
    int p;
    p = int'($signed(ia)) * int'($signed(ib)) + int'($signed(ic));
    return WIDTH'(p);
  endfunction

  function automatic bit m_valid();
    return hist.size() >= LATENCY;
  endfunction

  function automatic logic [WIDTH-1:0] m_exp();
    if (!m_valid()) return '0;
    return hist[hist.size() - LATENCY];
  endfunction

  task automatic model_reset();
    hist.delete();
    m_edges = 0; m_checks = 0; m_errs = 0; m_done = 0; m_mis = 0;
  endtask

  task automatic compare_all(input string ph);
    check_val({ph, "_exp_y"}, 32'(exp_y), 32'(m_exp()));
    check_val({ph, "_exp_valid"}, 32'(exp_valid), 32'(m_valid()));
    check_val({ph, "_mismatch"}, 32'(mismatch), 32'(m_mis));
    check_val({ph, "_err_count"}, 32'(err_count), 32'(m_errs));
    check_val({ph, "_check_count"}, check_count, 32'(m_checks));
    check_val({ph, "_done"}, 32'(done), 32'(m_done));
    check_val({ph, "_pass"}, 32'(pass), 32'(m_done && m_errs == 0));
  endtask

  task automatic step(input string ph, input logic [WIDTH-1:0] ia, ib, ic, input logic ien, input logic flip);
    logic [WIDTH-1:0] ey;
    ey = m_exp();
    a = ia; b = ib; c = ic; en = ien;
    y = ey ^ {{(WIDTH-1){1'b0}}, flip};
    m_mis = 0;
    if (!m_done && m_edges >= WARMUP && ien && m_valid()) begin
      m_checks++;
      if (flip) begin
        m_mis = 1;
        if (m_errs < 65535) m_errs++;
      end
      if (m_checks == NUM_CHECKS) m_done = 1;
    end
    m_edges++;
    if (ien) hist.push_back(gold(ia, ib, ic));
    @(posedge clock);
    #1;
    $display("%s a=%0d b=%0d c=%0d en=%0d y=%0d exp_y=%0d chk=%0d err=%0d done=%0d",
             ph, $signed(ia), $signed(ib), $signed(ic), ien, $signed(y), $signed(exp_y),
             check_count, err_count, done);
    compare_all(ph);
  endtask

  task automatic do_reset(input string ph);
    reset = 1'b0;
    model_reset();
    #2;
    compare_all({ph, "_rst"});
    @(negedge clock);
    reset = 1'b1;
  endtask

  function automatic bit flip_at(input int target, input logic e);
    return !m_done && m_edges >= WARMUP && e && m_valid() && m_checks == target;
  endfunction

  initial begin
    logic [WIDTH-1:0] ra, rb, rc;
    logic e;
    reset = 1'b1; en = 1'b0; a = '0; b = '0; c = '0; y = '0;
    #1;
    do_reset("init");

    // constant stream, then flips after done must be ignored
    for (int i = 0; i < 40; i++) step("A", 8'd127, 8'd1, 8'hCE, 1'b1, i >= 30);
    check_val("A_final_pass", 32'(pass), 32'd1);
    check_val("A_final_count", check_count, 32'(NUM_CHECKS));

    // wrap vectors, en toggling, one injected mismatch
    do_reset("B");
    for (int i = 0; i < 40; i++) begin
      if (i % 4 == 0) begin ra = 8'd127; rb = 8'd127; rc = 8'd0; end
      else if (i % 4 == 1) begin ra = 8'h80; rb = 8'd1; rc = 8'hFF; end
      else begin ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom); end
      e = (i >= 14 && i <= 17) ? (i % 2 == 0) : 1'b1;
      step("B", ra, rb, rc, e, flip_at(5, e));
    end
    check_val("B_final_pass", 32'(pass), 32'd0);
    check_val("B_final_err", 32'(err_count), 32'd1);
    check_val("B_final_count", check_count, 32'(NUM_CHECKS));

    // reset in the middle of checking, then random traffic with random errors
    do_reset("C");
    for (int i = 0; i < 60 && m_checks < 5; i++)
      step("C", 8'($urandom), 8'($urandom), 8'($urandom), 1'b1, 1'b0);
    check_val("C_mid_count", check_count, 32'd5);
    do_reset("C_mid");
    for (int i = 0; i < 80; i++) begin
      e = ($urandom_range(0, 3) != 0);
      step("D", 8'($urandom), 8'($urandom), 8'($urandom), e, ($urandom_range(0, 7) == 0));
    end

    // mismatch on the final compare
    do_reset("E");
    for (int i = 0; i < 32; i++)
      step("E", 8'($urandom), 8'($urandom), 8'($urandom), 1'b1, flip_at(NUM_CHECKS - 1, 1'b1));
    check_val("E_final_done", 32'(done), 32'd1);
    check_val("E_final_pass", 32'(pass), 32'd0);

    wait (sat_finished);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Long run: every compare mismatches, err_count must stop at 65535.
  initial begin
    int n;
    reset2 = 1'b1; en2 = 1'b1; a2 = '0; b2 = '0; c2 = '0; y2 = 8'd1;
    #1;
    reset2 = 1'b0;
    #20;
    @(negedge clock);
    reset2 = 1'b1;
    n = 0;
    while (n < 80000 && !done2) begin
      @(posedge clock);
      n++;
    end
    #1;
    check_val("sat_done", 32'(done2), 32'd1);
    check_val("sat_err_count", 32'(err_count2), 32'd65535);
    check_val("sat_check_count", check_count2, 32'(SAT_CHECKS));
    check_val("sat_pass", 32'(pass2), 32'd0);
    $display("SAT cycles=%0d chk=%0d err=%0d done=%0d pass=%0d", n, check_count2, err_count2, done2, pass2);
    sat_finished = 1'b1;
  end

endmodule
